frame_minmax_analyzer: RTL and testbench
========================================

// Module: frame_minmax_analyzer
// PURPOSE
// Per-frame statistics collector that produces the MIN/MAX bounds the contrast
// stretcher consumes. Observes one frame of 8-bit pixels over a valid/ready
// stream and tracks the darkest and brightest pixel. It then publishes the pair
// through a valid/ready handshake. Sits upstream of the stretch stage; published
// values drive its bounds for the next frame.
// PARAMETERS
// IMG_W     64   pixels per line
// IMG_H     64   lines per frame; frame length N = IMG_W*IMG_H (N >= 2)
// RST_MIN   50   min_out after reset, and fallback when the frame is degenerate
// RST_MAX   200  max_out after reset, and fallback when the frame is degenerate (RST_MAX > RST_MIN)
// MIN_SPAN  16   frame is degenerate if (max - min) < MIN_SPAN; must be >= 1 (prevents zero divisor downstream)
// PORTS
// clk          in   1  rising-edge clock
// rst          in   1  asynchronous reset, active-high
// start        in   1  single-cycle request to analyse the next frame
// pixel_in     in   8  pixel data
// pixel_valid  in   1  pixel_in is valid this cycle
// pixel_ready  out  1  block accepts a pixel this cycle (transfer = valid & ready)
// min_out      out  8  published frame minimum
// max_out      out  8  published frame maximum
// degenerate   out  1  last published frame failed the MIN_SPAN check
// stats_valid  out  1  min_out/max_out/degenerate hold a new result
// stats_ready  in   1  consumer takes the result (handshake = stats_valid & stats_ready)
// busy         out  1  high in ACCUM and PUBLISH
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, min_out=RST_MIN, max_out=RST_MAX, degenerate=0,
//   stats_valid=0, busy=0, count=0. A partial frame is discarded.
// - States are IDLE, ACCUM and PUBLISH. pixel_ready = (state==ACCUM), busy = (state!=IDLE), stats_valid = (state==PUBLISH).
// - IDLE: start=1 -> ACCUM. On that edge cur_min=255, cur_max=0, count=0.
// - ACCUM: each transfer updates cur_min=min(cur_min,pixel_in), cur_max=max(cur_max,pixel_in) and count++.
//   count is $clog2(N) bits wide. Gaps in pixel_valid stall the block with no effect.
// - Final transfer (count==N-1): on the same edge, go to PUBLISH. The final extrema include this last pixel.
//   The outputs load on the same edge:
//     span=fmax-fmin (8-bit, fmax>=fmin always). If span<MIN_SPAN: min_out=RST_MIN, max_out=RST_MAX, degenerate=1.
//     Otherwise min_out=fmin, max_out=fmax, degenerate=0.
//   Latency: stats_valid is high in the first cycle after the final pixel transfer.
// - PUBLISH: min_out, max_out and degenerate stay stable; stats_valid stays high until stats_ready.
//   On handshake: if start=1 in the same cycle, go to ACCUM (re-init as above); otherwise go to IDLE.
// - start is ignored in ACCUM, and in PUBLISH without a handshake. It is not queued.
// - min_out, max_out and degenerate change only on the final-transfer edge or on reset.
//   They never move mid-frame, so downstream may sample them at any time.
// - pixel_valid in IDLE/PUBLISH is ignored; nothing is transferred.
// TESTING (bench uses IMG_W=4, IMG_H=2 -> N=8, other params default)
// 1 Reset mid-run, then release -> min_out=50, max_out=200, degenerate=0, stats_valid=0, pixel_ready=0, busy=0.
// 2 start; feed 60,90,120,30,240,100,70,80 back-to-back -> stats_valid=1 the cycle after the 8th transfer,
//   min_out=30, max_out=240, degenerate=0; stats_ready=1 -> IDLE next cycle.
// 3 Same frame with pixel_valid toggling every cycle; hold stats_ready=0 for 5 cycles -> identical results.
//   stats_valid stays high, outputs stay stable, pixel_ready=0 throughout PUBLISH.
// 4 Frame of eight 128s -> degenerate=1, min_out=50, max_out=200.
//   Frame spanning 100..116 -> degenerate=0, min_out=100, max_out=116.
//   Frame spanning 100..115 -> degenerate=1.
// 5 Assert rst after 3 pixels of a frame -> all outputs return to reset values.
//   Then start and a full frame 10..250 -> min_out=10, max_out=250.
// 6 start and stats_ready together in PUBLISH -> ACCUM next cycle, and the next frame publishes correctly.
//   start pulsed during ACCUM -> no re-init; count and extrema unaffected.

Source files
------------

// File: rtl/frame_minmax_analyzer.sv
// frame_minmax_analyzer
// Collects the darkest and brightest pixel of one frame and publishes the
// pair as MIN/MAX bounds for the downstream contrast stretcher. Degenerate
// frames (span below MIN_SPAN) publish the fallback bounds instead.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   start                         request to analyse the next frame
//   pixel_in/pixel_valid/ready    pixel stream (transfer = valid & ready)
//   min_out, max_out, degenerate  published result, stable between frames
//   stats_valid/stats_ready       result handshake
//   busy                          high while accumulating or publishing
module frame_minmax_analyzer #(
    parameter int unsigned IMG_W    = 64,
    parameter int unsigned IMG_H    = 64,
    parameter int unsigned RST_MIN  = 50,
    parameter int unsigned RST_MAX  = 200,
    parameter int unsigned MIN_SPAN = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] pixel_in,
    input  logic       pixel_valid,
    output logic       pixel_ready,
    output logic [7:0] min_out,
    output logic [7:0] max_out,
    output logic       degenerate,
    output logic       stats_valid,
    input  logic       stats_ready,
    output logic       busy
);

    localparam int unsigned N     = IMG_W * IMG_H;
    localparam int unsigned CNT_W = $clog2(N);

    typedef enum logic [1:0] {IDLE, ACCUM, PUBLISH} state_t;

    state_t             state;
    logic [7:0]         cur_min;
    logic [7:0]         cur_max;
    logic [CNT_W-1:0]   count;

    logic [7:0]         fmin_c;
    logic [7:0]         fmax_c;
    logic [7:0]         span_c;
    logic               last_c;

    // Extrema including the pixel presented this cycle; used both for the
    // running update and for the final-transfer publish.
    always_comb begin
        fmin_c = (pixel_in < cur_min) ? pixel_in : cur_min;
        fmax_c = (pixel_in > cur_max) ? pixel_in : cur_max;
        span_c = fmax_c - fmin_c;
        last_c = (count == CNT_W'(N - 1));
    end

    // State, accumulators and registered outputs. Status outputs are updated
    // together with the state so they always equal its decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cur_min     <= 8'd255;
            cur_max     <= 8'd0;
            count       <= '0;
            min_out     <= 8'(RST_MIN);
            max_out     <= 8'(RST_MAX);
            degenerate  <= 1'b0;
            stats_valid <= 1'b0;
            pixel_ready <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= ACCUM;
                        cur_min     <= 8'd255;
                        cur_max     <= 8'd0;
                        count       <= '0;
                        pixel_ready <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (pixel_valid) begin
                        cur_min <= fmin_c;
                        cur_max <= fmax_c;
                        count   <= count + CNT_W'(1);
                        if (last_c) begin
                            state       <= PUBLISH;
                            pixel_ready <= 1'b0;
                            stats_valid <= 1'b1;
                            if (span_c < 8'(MIN_SPAN)) begin
                                min_out    <= 8'(RST_MIN);
                                max_out    <= 8'(RST_MAX);
                                degenerate <= 1'b1;
                            end else begin
                                min_out    <= fmin_c;
                                max_out    <= fmax_c;
                                degenerate <= 1'b0;
                            end
                        end
                    end
                end
                PUBLISH: begin
                    if (stats_ready) begin
                        stats_valid <= 1'b0;
                        if (start) begin
                            state       <= ACCUM;
                            cur_min     <= 8'd255;
                            cur_max     <= 8'd0;
                            count       <= '0;
                            pixel_ready <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    stats_valid <= 1'b0;
                    pixel_ready <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_minmax_analyzer.sv
// tb_frame_minmax_analyzer
// Directed bench for frame_minmax_analyzer with an 8-pixel frame (4x2).
module tb_frame_minmax_analyzer;

    typedef logic [7:0] frame_t [8];

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] pixel_in;
    logic       pixel_valid;
    logic       pixel_ready;
    logic [7:0] min_out;
    logic [7:0] max_out;
    logic       degenerate;
    logic       stats_valid;
    logic       stats_ready;
    logic       busy;

    int checks = 0;
    int fails  = 0;

    frame_minmax_analyzer #(
        .IMG_W(4), .IMG_H(2), .RST_MIN(50), .RST_MAX(200), .MIN_SPAN(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .pixel_in(pixel_in), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .min_out(min_out), .max_out(max_out), .degenerate(degenerate),
        .stats_valid(stats_valid), .stats_ready(stats_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Feeds 8 pixels; optional idle gap (garbage 0 on pixel_in) between
    // pixels, optional start pulse alongside pixel index start_at.
    task automatic feed(input frame_t f, input bit gaps, input int start_at);
        for (int i = 0; i < 8; i++) begin
            pixel_in    = f[i];
            pixel_valid = 1'b1;
            start       = (i == start_at);
            step();
            start = 1'b0;
            if (gaps && i < 7) begin
                pixel_valid = 1'b0;
                pixel_in    = 8'd0;
                step();
            end
        end
        pixel_valid = 1'b0;
    endtask

    task automatic handshake();
        stats_ready = 1'b1;
        step();
        stats_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        do_start();
        pixel_valid = 1'b1; pixel_in = 8'd1;
        step(); step();
        pixel_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_async_busy got %0b exp 0", busy); end
        step();
        rst = 1'b0;
        step();
        checks++; if (min_out !== 8'd50) begin fails++; $display("FAIL reset_min got %0d exp 50", min_out); end
        checks++; if (max_out !== 8'd200) begin fails++; $display("FAIL reset_max got %0d exp 200", max_out); end
        checks++; if (degenerate !== 1'b0) begin fails++; $display("FAIL reset_deg got %0b exp 0", degenerate); end
        checks++; if (stats_valid !== 1'b0) begin fails++; $display("FAIL reset_sv got %0b exp 0", stats_valid); end
        checks++; if (pixel_ready !== 1'b0) begin fails++; $display("FAIL reset_pr got %0b exp 0", pixel_ready); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b exp 0", busy); end
    endtask

    task automatic test_basic_frame();
        frame_t f = '{8'd60, 8'd90, 8'd120, 8'd30, 8'd240, 8'd100, 8'd70, 8'd80};
        // pixel_valid in IDLE must not transfer
        pixel_valid = 1'b1; pixel_in = 8'd5;
        step();
        pixel_valid = 1'b0;
        do_start();
        checks++; if (pixel_ready !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL accum_status got pr=%0b busy=%0b exp 1/1", pixel_ready, busy); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (stats_valid !== 1'b0) begin fails++; $display("FAIL early_sv idx %0d got %0b exp 0", i, stats_valid); end
            pixel_in = f[i]; pixel_valid = 1'b1;
            step();
        end
        pixel_valid = 1'b0;
        checks++; if (stats_valid !== 1'b1) begin fails++; $display("FAIL basic_sv got %0b exp 1", stats_valid); end
        checks++; if (min_out !== 8'd30) begin fails++; $display("FAIL basic_min got %0d exp 30", min_out); end
        checks++; if (max_out !== 8'd240) begin fails++; $display("FAIL basic_max got %0d exp 240", max_out); end
        checks++; if (degenerate !== 1'b0) begin fails++; $display("FAIL basic_deg got %0b exp 0", degenerate); end
        checks++; if (pixel_ready !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL publish_status got pr=%0b busy=%0b exp 0/1", pixel_ready, busy); end
        handshake();
        checks++; if (stats_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL basic_idle got sv=%0b busy=%0b exp 0/0", stats_valid, busy); end
    endtask

    task automatic test_gaps_and_hold();
        frame_t f = '{8'd60, 8'd90, 8'd120, 8'd30, 8'd240, 8'd100, 8'd70, 8'd80};
        do_start();
        feed(f, 1'b1, -1);
        for (int c = 0; c < 5; c++) begin
            start = (c == 2);   // ignored without handshake
            checks++;
            if (stats_valid !== 1'b1 || min_out !== 8'd30 || max_out !== 8'd240 ||
                degenerate !== 1'b0 || pixel_ready !== 1'b0) begin
                fails++;
                $display("FAIL hold cycle %0d got sv=%0b min=%0d max=%0d deg=%0b pr=%0b exp 1/30/240/0/0",
                         c, stats_valid, min_out, max_out, degenerate, pixel_ready);
            end
            step();
            start = 1'b0;
        end
        handshake();
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL hold_idle busy got %0b exp 0", busy); end
    endtask

    task automatic test_degenerate();
        frame_t flat = '{default: 8'd128};
        frame_t s16  = '{8'd100, 8'd116, 8'd105, 8'd110, 8'd101, 8'd115, 8'd108, 8'd112};
        frame_t s15  = '{8'd100, 8'd115, 8'd105, 8'd110, 8'd101, 8'd114, 8'd108, 8'd112};
        do_start(); feed(flat, 1'b0, -1);
        checks++; if (degenerate !== 1'b1 || min_out !== 8'd50 || max_out !== 8'd200) begin fails++; $display("FAIL flat got deg=%0b min=%0d max=%0d exp 1/50/200", degenerate, min_out, max_out); end
        handshake();
        do_start(); feed(s16, 1'b0, -1);
        checks++; if (degenerate !== 1'b0 || min_out !== 8'd100 || max_out !== 8'd116) begin fails++; $display("FAIL span16 got deg=%0b min=%0d max=%0d exp 0/100/116", degenerate, min_out, max_out); end
        handshake();
        do_start(); feed(s15, 1'b0, -1);
        checks++; if (degenerate !== 1'b1 || min_out !== 8'd50 || max_out !== 8'd200) begin fails++; $display("FAIL span15 got deg=%0b min=%0d max=%0d exp 1/50/200", degenerate, min_out, max_out); end
        handshake();
    endtask

    task automatic test_reset_mid_frame();
        frame_t f = '{8'd10, 8'd250, 8'd40, 8'd90, 8'd130, 8'd170, 8'd200, 8'd60};
        do_start();
        for (int i = 0; i < 3; i++) begin
            pixel_in = 8'd128; pixel_valid = 1'b1;
            step();
        end
        pixel_valid = 1'b0;
        rst = 1'b1; step(); rst = 1'b0; step();
        checks++;
        if (min_out !== 8'd50 || max_out !== 8'd200 || degenerate !== 1'b0 ||
            stats_valid !== 1'b0 || pixel_ready !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL midreset got min=%0d max=%0d deg=%0b sv=%0b pr=%0b busy=%0b exp 50/200/0/0/0/0",
                     min_out, max_out, degenerate, stats_valid, pixel_ready, busy);
        end
        do_start(); feed(f, 1'b0, -1);
        checks++; if (stats_valid !== 1'b1 || min_out !== 8'd10 || max_out !== 8'd250) begin fails++; $display("FAIL after_reset_frame got sv=%0b min=%0d max=%0d exp 1/10/250", stats_valid, min_out, max_out); end
    endtask

    // Entered while still in PUBLISH from the previous task.
    task automatic test_back_to_back();
        frame_t f = '{8'd20, 8'd40, 8'd60, 8'd80, 8'd100, 8'd120, 8'd140, 8'd160};
        start = 1'b1; stats_ready = 1'b1;
        step();
        start = 1'b0; stats_ready = 1'b0;
        checks++; if (pixel_ready !== 1'b1 || stats_valid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL b2b_accum got pr=%0b sv=%0b busy=%0b exp 1/0/1", pixel_ready, stats_valid, busy); end
        checks++; if (min_out !== 8'd10 || max_out !== 8'd250) begin fails++; $display("FAIL b2b_stable got min=%0d max=%0d exp 10/250", min_out, max_out); end
        // start pulse on the 4th pixel must not restart the frame
        for (int i = 0; i < 7; i++) begin
            pixel_in = f[i]; pixel_valid = 1'b1; start = (i == 3);
            step();
            start = 1'b0;
        end
        checks++; if (stats_valid !== 1'b0 || min_out !== 8'd10) begin fails++; $display("FAIL b2b_midframe got sv=%0b min=%0d exp 0/10", stats_valid, min_out); end
        pixel_in = f[7];
        step();
        pixel_valid = 1'b0;
        checks++; if (stats_valid !== 1'b1 || min_out !== 8'd20 || max_out !== 8'd160 || degenerate !== 1'b0) begin fails++; $display("FAIL b2b_result got sv=%0b min=%0d max=%0d deg=%0b exp 1/20/160/0", stats_valid, min_out, max_out, degenerate); end
        handshake();
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle busy got %0b exp 0", busy); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pixel_in = 8'd0; pixel_valid = 1'b0; stats_ready = 1'b0;
        step(); step();
        test_reset();
        test_basic_frame();
        test_gaps_and_hold();
        test_degenerate();
        test_reset_mid_frame();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
